r16_fft_ctrl: RTL and testbench

Frame sequencer for the radix-16 16384-point FFT datapath. It moves one frame through five steps: it loads the input samples (write-feed mode), runs the compute passes, drains the pipeline, unloads the results (row/column read mode), and flushes. It produces the AGU control inputs `AGU_en`, `rc_sel_in` and `wrfd_en_in`, plus frame-level `start`/`busy`/`done` handshakes, and sits between the system front-end and the AGU/memory/butterfly core.

---
 rtl/r16_fft_ctrl.sv | 152 +++++++++++++++
 tb/tb_r16_fft_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r16_fft_ctrl.sv
// r16_fft_ctrl -- frame sequencer for the radix-16 16384-point FFT datapath.
//
// Moves one frame through LOAD -> COMP -> DRAIN -> UNLOAD -> FLUSH -> DONE
// and generates the AGU controls (AGU_en, rc_sel_in, wrfd_en_in) plus the
// frame-level busy/done handshakes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      frame request; only looked at in IDLE
//   abort      cancel the current frame from any state (no done)
//   in_valid   input word present
//   in_ready   block accepts input words (LOAD)
//   wrfd_en    -> AGU wrfd_en_in; accepted input word this cycle
//   agu_en     -> AGU AGU_en; high in COMP and UNLOAD
//   rc_sel     -> AGU rc_sel_in; row/column read mode, high in UNLOAD
//   out_valid  memory read port carries a valid result word
//   stage      compute stage (cnt[12:10]) during COMP, else 0
//   busy       any state other than IDLE
//   done       one-cycle pulse at frame completion
module r16_fft_ctrl #(
  parameter int CNT_W      = 13,
  parameter int LOAD_LEN   = 1024,
  parameter int COMP_LEN   = 4144,
  parameter int DRAIN_LEN  = 2,
  parameter int UNLOAD_LEN = 1026,
  parameter int RD_LAT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wrfd_en,
  output logic       agu_en,
  output logic       rc_sel,
  output logic       out_valid,
  output logic [2:0] stage,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMP, S_DRAIN, S_UNLOAD, S_FLUSH, S_DONE
  } state_t;

  // Terminal counts, compared at full counter width.
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] COMP_LAST   = CNT_W'(COMP_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_LEN - 1);
  localparam logic [CNT_W-1:0] UNLOAD_LAST = CNT_W'(UNLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RD_LAT:1]  vld_pipe;   // read-valid shift register, [RD_LAT] is oldest
  logic             rd_issue;

  // Outputs decode the registered state only; wrfd_en is the single
  // combinational path from an input.
  assign in_ready  = (state == S_LOAD);
  assign wrfd_en   = in_valid & in_ready;
  assign agu_en    = (state == S_COMP) || (state == S_UNLOAD);
  assign rc_sel    = (state == S_UNLOAD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign stage     = (state == S_COMP) ? 3'(cnt >> 10) : 3'd0;
  assign rd_issue  = agu_en & rc_sel;
  assign out_valid = vld_pipe[RD_LAT];

  // Sequencer. cnt is cleared on every state entry, so each phase counts
  // 0..LEN-1 and the counter never wraps inside a state. abort shares the
  // reset path: it beats every other transition and skips DONE.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          // Gaps in in_valid simply hold the counter.
          if (in_valid) begin
            if (cnt == LOAD_LAST) begin
              state <= S_COMP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        S_COMP: begin
          if (cnt == COMP_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            state <= S_UNLOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_UNLOAD: begin
          if (cnt == UNLOAD_LAST) begin
            state <= S_FLUSH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_FLUSH: begin
          // Holds until the last unload read has left the valid pipe.
          if (cnt == FLUSH_LAST) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // out_valid mirrors the unload reads delayed by the memory read latency.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_r16_fft_ctrl.sv
// Bench for r16_fft_ctrl: a small-parameter instance (u_small) and a
// default-parameter instance (u_dflt) share one clock. The stimulus process
// pushes the expected output-change events and the expected full output
// snapshots for given cycles; one monitor process pops and compares them.
module tb_r16_fft_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       s_rst, s_start, s_abort, s_in_valid;
  logic       s_in_ready, s_wrfd_en, s_agu_en, s_rc_sel, s_out_valid, s_busy, s_done;
  logic [2:0] s_stage;
  logic       d_rst, d_start, d_abort, d_in_valid;
  logic       d_in_ready, d_wrfd_en, d_agu_en, d_rc_sel, d_out_valid, d_busy, d_done;
  logic [2:0] d_stage;

  r16_fft_ctrl #(
    .CNT_W(13), .LOAD_LEN(4), .COMP_LEN(8), .DRAIN_LEN(2), .UNLOAD_LEN(3), .RD_LAT(2)
  ) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .wrfd_en(s_wrfd_en), .agu_en(s_agu_en), .rc_sel(s_rc_sel),
    .out_valid(s_out_valid), .stage(s_stage), .busy(s_busy), .done(s_done)
  );

  r16_fft_ctrl u_dflt (
    .clk(clk), .rst(d_rst), .start(d_start), .abort(d_abort), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .wrfd_en(d_wrfd_en), .agu_en(d_agu_en), .rc_sel(d_rc_sel),
    .out_valid(d_out_valid), .stage(d_stage), .busy(d_busy), .done(d_done)
  );

  // Event vector: {busy, in_ready, agu_en, rc_sel, out_valid, wrfd_en, done}
  // Snapshot vector: {in_ready, wrfd_en, agu_en, rc_sel, out_valid, stage, busy, done}
  typedef struct packed { int cyc; logic [6:0] v; } ev_t;
  typedef struct packed { int cyc; logic [9:0] v; } snap_t;

  ev_t   s_evq[$], d_evq[$];
  snap_t s_snq[$], d_snq[$];
  int    n_cmp = 0, n_bad = 0;
  logic  mon_en = 1'b0, fin = 1'b0, fin_ack = 1'b0;

  logic [6:0] s_ev, d_ev, s_prev, d_prev;
  logic [9:0] s_sn, d_sn;
  ev_t        mon_e;
  snap_t      mon_sn;

  assign s_ev = {s_busy, s_in_ready, s_agu_en, s_rc_sel, s_out_valid, s_wrfd_en, s_done};
  assign d_ev = {d_busy, d_in_ready, d_agu_en, d_rc_sel, d_out_valid, d_wrfd_en, d_done};
  assign s_sn = {s_in_ready, s_wrfd_en, s_agu_en, s_rc_sel, s_out_valid, s_stage, s_busy, s_done};
  assign d_sn = {d_in_ready, d_wrfd_en, d_agu_en, d_rc_sel, d_out_valid, d_stage, d_busy, d_done};

  function automatic ev_t mke(input int c, input logic [6:0] v);
    ev_t e;
    e.cyc = c; e.v = v;
    return e;
  endfunction

  function automatic snap_t mks(input int c, input logic [9:0] v);
    snap_t s;
    s.cyc = c; s.v = v;
    return s;
  endfunction

  function automatic logic [9:0] mk(input logic ir, input logic wr, input logic agu,
                                    input logic rc, input logic ov, input logic [2:0] stg,
                                    input logic bsy, input logic dn);
    return {ir, wr, agu, rc, ov, stg, bsy, dn};
  endfunction

  task automatic cmp(input string nm, input int gc, input logic [9:0] gv,
                     input int ec, input logic [9:0] ev);
    n_cmp++;
    if (gc != ec || gv !== ev) begin
      n_bad++;
      $display("FAIL %s: got cyc=%0d vec=%b, required cyc=%0d vec=%b", nm, gc, gv, ec, ev);
    end
  endtask

  // Monitor: every change of a DUT's output vector consumes one expected
  // event; snapshots are compared on their scheduled cycle.
  always @(negedge clk) begin
    if (!mon_en) begin
      s_prev = s_ev;
      d_prev = d_ev;
    end else begin
      if (s_ev != s_prev) begin
        s_prev = s_ev;
        if (s_evq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL s_event: got cyc=%0d vec=%b, required no change", cyc, s_ev);
        end else begin
          mon_e = s_evq.pop_front();
          cmp("s_event", cyc, {3'b000, s_ev}, mon_e.cyc, {3'b000, mon_e.v});
        end
      end
      if (d_ev != d_prev) begin
        d_prev = d_ev;
        if (d_evq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_event: got cyc=%0d vec=%b, required no change", cyc, d_ev);
        end else begin
          mon_e = d_evq.pop_front();
          cmp("d_event", cyc, {3'b000, d_ev}, mon_e.cyc, {3'b000, mon_e.v});
        end
      end
    end
    while (s_snq.size() != 0 && s_snq[0].cyc <= cyc) begin
      mon_sn = s_snq.pop_front();
      cmp("s_snap", cyc, s_sn, mon_sn.cyc, mon_sn.v);
    end
    while (d_snq.size() != 0 && d_snq[0].cyc <= cyc) begin
      mon_sn = d_snq.pop_front();
      cmp("d_snap", cyc, d_sn, mon_sn.cyc, mon_sn.v);
    end
    if (fin && !fin_ack) begin
      n_cmp++;
      if (s_evq.size() + d_evq.size() + s_snq.size() + d_snq.size() != 0) begin
        n_bad++;
        $display("FAIL queues_drained: got pending s_ev=%0d d_ev=%0d s_snap=%0d d_snap=%0d, required 0",
                 s_evq.size(), d_evq.size(), s_snq.size(), d_snq.size());
      end
      fin_ack = 1'b1;
    end
  end

  // Small-config frame tail, relative to the cycle u of the last accepted word.
  task automatic s_tail(input int u);
    s_evq.push_back(mke(u + 1,  7'b1010000));  // COMP
    s_evq.push_back(mke(u + 9,  7'b1000000));  // DRAIN
    s_evq.push_back(mke(u + 11, 7'b1011000));  // UNLOAD
    s_evq.push_back(mke(u + 13, 7'b1011100));  // first out_valid
    s_evq.push_back(mke(u + 14, 7'b1000100));  // FLUSH
    s_evq.push_back(mke(u + 16, 7'b1000001));  // DONE
    s_evq.push_back(mke(u + 17, 7'b0000000));  // IDLE
  endtask

  // Default-config frame with in_valid held high, start at cycle t.
  task automatic d_frame(input int t);
    d_evq.push_back(mke(t + 1,    7'b1100010));  // LOAD
    d_evq.push_back(mke(t + 1025, 7'b1010000));  // COMP, 4144 cycles
    d_evq.push_back(mke(t + 5169, 7'b1000000));  // DRAIN
    d_evq.push_back(mke(t + 5171, 7'b1011000));  // UNLOAD, 1026 cycles
    d_evq.push_back(mke(t + 5173, 7'b1011100));
    d_evq.push_back(mke(t + 6197, 7'b1000100));  // FLUSH
    d_evq.push_back(mke(t + 6199, 7'b1000001));  // DONE
    d_evq.push_back(mke(t + 6200, 7'b0000000));  // IDLE
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got cyc=%0d, required finish before time limit", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_rst = 1'b1; s_start = 1'b1; s_abort = 1'b0; s_in_valid = 1'b1;
    d_rst = 1'b1; d_start = 1'b0; d_abort = 1'b0; d_in_valid = 1'b1;
    // Reset values, with start and in_valid high during reset.
    s_snq.push_back(mks(1, '0)); s_snq.push_back(mks(2, '0));
    d_snq.push_back(mks(1, '0)); d_snq.push_back(mks(2, '0));
    goto(3);
    s_rst = 1'b0; d_rst = 1'b0; s_start = 1'b0; mon_en = 1'b1;

    // Small frame, in_valid high, start at 3.
    s_start = 1'b1;
    s_evq.push_back(mke(4, 7'b1100010));
    s_tail(7);
    s_snq.push_back(mks(4, mk(1, 1, 0, 0, 0, 3'd0, 1, 0)));
    // Default back-to-back frames with start held high from 3.
    d_start = 1'b1;
    d_frame(3);
    d_frame(6203);
    d_snq.push_back(mks(4028, mk(0, 0, 1, 0, 0, 3'd2, 1, 0)));  // COMP cnt=3000
    d_snq.push_back(mks(5171, mk(0, 0, 1, 0, 0, 3'd4, 1, 0)));  // COMP cnt=4143
    d_snq.push_back(mks(5172, mk(0, 0, 0, 0, 0, 3'd0, 1, 0)));  // DRAIN
    step(); s_start = 1'b0;
    goto(13); s_start = 1'b1; step(); s_start = 1'b0;  // ignored while busy

    // Small frame with in_valid toggling 1,0,1,0...
    goto(30);
    s_start = 1'b1; s_in_valid = 1'b0;
    s_evq.push_back(mke(31, 7'b1100010)); s_evq.push_back(mke(32, 7'b1100000));
    s_evq.push_back(mke(33, 7'b1100010)); s_evq.push_back(mke(34, 7'b1100000));
    s_evq.push_back(mke(35, 7'b1100010)); s_evq.push_back(mke(36, 7'b1100000));
    s_evq.push_back(mke(37, 7'b1100010));
    s_tail(37);
    for (int k = 0; k < 8; k++) begin
      step();
      s_start = 1'b0;
      s_in_valid = (k % 2 == 0);
    end
    goto(42); s_start = 1'b1; step(); s_start = 1'b0;

    // rst during UNLOAD, then a fresh frame.
    goto(60);
    s_start = 1'b1; s_in_valid = 1'b1;
    s_evq.push_back(mke(61, 7'b1100010)); s_evq.push_back(mke(65, 7'b1010000));
    s_evq.push_back(mke(73, 7'b1000000)); s_evq.push_back(mke(75, 7'b1011000));
    s_evq.push_back(mke(77, 7'b0000000));
    s_snq.push_back(mks(76, mk(0, 0, 1, 1, 0, 3'd0, 1, 0)));
    s_snq.push_back(mks(77, '0));
    step(); s_start = 1'b0;
    goto(68); s_start = 1'b1; step(); s_start = 1'b0;
    goto(76); s_rst = 1'b1; step(); s_rst = 1'b0;
    goto(80);
    s_start = 1'b1;
    s_evq.push_back(mke(81, 7'b1100010));
    s_tail(84);
    step(); s_start = 1'b0;

    // start and abort together in IDLE.
    goto(110);
    s_start = 1'b1; s_abort = 1'b1; s_in_valid = 1'b0;
    s_snq.push_back(mks(111, '0));
    step(); s_start = 1'b0; s_abort = 1'b0;

    goto(6303); d_start = 1'b0;

    // Default frame aborted at COMP cycle 100.
    goto(12410);
    d_start = 1'b1;
    d_evq.push_back(mke(12411, 7'b1100010));
    d_evq.push_back(mke(13435, 7'b1010000));
    d_evq.push_back(mke(13536, 7'b0000000));
    d_snq.push_back(mks(13535, mk(0, 0, 1, 0, 0, 3'd0, 1, 0)));
    d_snq.push_back(mks(13536, '0));
    step(); d_start = 1'b0;
    goto(13535); d_abort = 1'b1; step(); d_abort = 1'b0;

    goto(13560);
    fin = 1'b1;
    wait (fin_ack);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
